vga_dither_sequencer: RTL and testbench

//  Sequences the VGA output path around three external 8-bit dithering engines (R,G,B): generates raster

---
 rtl/vga_dither_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_dither_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dither_sequencer.sv
// Purpose : raster timing + framebuffer read sequencing around external R/G/B dither engines, sync aligned to colour.
// Latency : 2 clk from framebuffer address/read strobe to vga_rgb; hsync/vsync/frame_start share that delay.
// Backpressure: none; one pixel per clock, the RAM must answer every read one clock later.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-low reset
//   dither_on         dithered (1) or truncated (0) colour, taken once per frame
//   fb_addr/fb_rd     linear raster-order read address and strobe; fb_data returns one clock later
//   dith_in/dith_out  colour to / from the three combinational dither engines
//   dith_visible      engine qualifier, low during every blanking interval (clears engine error)
//   dith_rst          active-high engine reset, held one clock past reset release
//   vga_rgb, hsync, vsync, frame_start   registered DAC/pin outputs
// Optional feature: define DITHER_TESTPAT_EN to add input test_pat, which replaces framebuffer
// data with a horizontal grey ramp for the whole frame (selected at the frame boundary).

module vga_dither_sequencer #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   AW       = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dither_on,
`ifdef DITHER_TESTPAT_EN
    input  logic          test_pat,
`endif
    output logic [AW-1:0] fb_addr,
    output logic          fb_rd,
    input  logic [23:0]   fb_data,
    output logic [23:0]   dith_in,
    output logic          dith_visible,
    output logic          dith_rst,
    input  logic [23:0]   dith_out,
    output logic [23:0]   vga_rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [AW-1:0] ADDR_MAX = AW'(H_VIS * V_VIS - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_H_BLANK = 2'd1,
        ST_V_BLANK = 2'd2
    } raster_st_t;

    // ---------------- stage 0: raster counters and read issue ----------------
    raster_st_t    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [AW-1:0] addr_q, addr_d;
    // run_q holds the raster at (0,0) for the first clock after reset release,
    // so fb_rd stays low while rst is asserted even though (0,0) is visible.
    logic          run_q;
    logic          act_s0;
    logic          rd_s0;
    logic          hs_s0;
    logic          vs_s0;
    logic          frame_s0;

    assign act_s0   = run_q && (state_q == ST_ACTIVE);
    assign frame_s0 = run_q && (h_q == '0) && (v_q == '0);
    assign hs_s0    = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_s0    = (v_q >= VS_BEG) && (v_q < VS_END);

    // Per-frame mode bits, updated only at the frame boundary so a frame is never mixed.
    logic dith_on_q;

`ifdef DITHER_TESTPAT_EN
    logic       tp_q;
    logic       tp_s0;
    logic       tp_d1_q;
    logic [7:0] hlo_d1_q;

    // Pixel (0,0) already belongs to the new frame, so it sees the incoming test_pat value.
    assign tp_s0 = frame_s0 ? test_pat : tp_q;
    assign rd_s0 = act_s0 && !tp_s0;
`else
    assign rd_s0 = act_s0;
`endif

    assign fb_rd   = rd_s0;
    assign fb_addr = addr_q;

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        addr_d  = addr_q;
        state_d = state_q;
        if (run_q) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // The address advances on visible pixels even in test-pattern frames so the
            // next framebuffer frame still starts at address 0.
            if (act_s0) begin
                addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
            end
            if (v_d >= V_VIS_C) begin
                state_d = ST_V_BLANK;
            end else if (h_d >= H_VIS_C) begin
                state_d = ST_H_BLANK;
            end else begin
                state_d = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ACTIVE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            run_q   <= 1'b1;
        end
    end

    // ---------------- stage 1: engine feed ----------------
    logic vis_d1_q;
    logic hs_d1_q;
    logic vs_d1_q;
    logic fs_d1_q;
    logic dith_rst_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vis_d1_q   <= 1'b0;
            hs_d1_q    <= ~SYNC_POL;
            vs_d1_q    <= ~SYNC_POL;
            fs_d1_q    <= 1'b0;
            dith_on_q  <= 1'b0;
            dith_rst_q <= 1'b1;
        end else begin
            vis_d1_q   <= act_s0;
            hs_d1_q    <= hs_s0 ? SYNC_POL : ~SYNC_POL;
            vs_d1_q    <= vs_s0 ? SYNC_POL : ~SYNC_POL;
            fs_d1_q    <= frame_s0;
            // Registered from ~run_q: releases one clock after the raster starts, just as
            // the first pixel reaches the engines.
            dith_rst_q <= ~run_q;
            if (frame_s0) begin
                dith_on_q <= dither_on;
            end
        end
    end

`ifdef DITHER_TESTPAT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            tp_q     <= 1'b0;
            tp_d1_q  <= 1'b0;
            hlo_d1_q <= '0;
        end else begin
            tp_q     <= tp_s0;
            tp_d1_q  <= tp_s0;
            hlo_d1_q <= 8'(h_q);
        end
    end

    assign dith_in = !vis_d1_q ? 24'h0 :
                     tp_d1_q   ? {3{hlo_d1_q}} : fb_data;
`else
    assign dith_in = vis_d1_q ? fb_data : 24'h0;
`endif

    assign dith_visible = vis_d1_q;
    assign dith_rst     = dith_rst_q;

    // ---------------- stage 2: colour select and output registers ----------------
    logic [23:0] trunc_rgb;
    logic [23:0] rgb_d;
    logic [23:0] rgb_q;
    logic        hs_d2_q;
    logic        vs_d2_q;
    logic        fs_d2_q;

    assign trunc_rgb = {dith_in[23:20], 4'h0, dith_in[15:12], 4'h0, dith_in[7:4], 4'h0};

    always_comb begin
        rgb_d = 24'h0;
        if (vis_d1_q) begin
            rgb_d = dith_on_q ? dith_out : trunc_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q   <= 24'h0;
            hs_d2_q <= ~SYNC_POL;
            vs_d2_q <= ~SYNC_POL;
            fs_d2_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hs_d2_q <= hs_d1_q;
            vs_d2_q <= vs_d1_q;
            fs_d2_q <= fs_d1_q;
        end
    end

    assign vga_rgb     = rgb_q;
    assign hsync       = hs_d2_q;
    assign vsync       = vs_d2_q;
    assign frame_start = fs_d2_q;

endmodule

// File: tb/tb_vga_dither_sequencer.sv
// Purpose : self-checking bench for vga_dither_sequencer with small raster parameters.
// Latency : expectations derived from absolute pixel time since reset release.
// Backpressure: not applicable; the framebuffer RAM and dither engines are modelled here.

module tb_vga_dither_sequencer;

    localparam int HV = 16, HFP = 2, HSY = 3, HBP = 2;
    localparam int VV = 4,  VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HV + HFP + HSY + HBP;   // 23
    localparam int VT = VV + VFP + VSY + VBP;   // 7
    localparam int FR = HT * VT;                // 161
    localparam int NP = HV * VV;                // 64
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          dither_on;
    logic [AW-1:0] fb_addr;
    logic          fb_rd;
    logic [23:0]   fb_data = 24'h0;
    logic [23:0]   dith_in;
    logic          dith_visible;
    logic          dith_rst;
    logic [23:0]   dith_out;
    logic [23:0]   vga_rgb;
    logic          hsync, vsync, frame_start;

    always #5 clk = ~clk;

    vga_dither_sequencer #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(1'b0), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .dither_on(dither_on),
`ifdef DITHER_TESTPAT_EN
        .test_pat(1'b0),
`endif
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .dith_in(dith_in), .dith_visible(dith_visible), .dith_rst(dith_rst),
        .dith_out(dith_out), .vga_rgb(vga_rgb),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    // ---------------- environment: framebuffer RAM and dither engines ----------------
    logic [23:0] mem [NP];

    always @(posedge clk) begin
        if (fb_rd) fb_data <= mem[fb_addr];
    end

    function automatic int clamp8(int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    // Round to a multiple of 16, capped at 240.
    function automatic int quant(int s);
        int q;
        q = ((s + 8) / 16) * 16;
        if (q > 240) q = 240;
        return q;
    endfunction

    int eerr [3];
    initial for (int c = 0; c < 3; c++) eerr[c] = 0;

    always_comb begin
        dith_out = 24'h0;
        for (int c = 0; c < 3; c++)
            dith_out[8*c +: 8] = 8'(quant(clamp8(int'(dith_in[8*c +: 8]) + eerr[c])));
    end

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (dith_rst || !dith_visible) eerr[c] <= 0;
            else eerr[c] <= clamp8(int'(dith_in[8*c +: 8]) + eerr[c])
                            - quant(clamp8(int'(dith_in[8*c +: 8]) + eerr[c]));
        end
    end

    // ---------------- reference model: functions of absolute pixel time ----------------
    function automatic logic act(int p);
        int h, v;
        h = p % HT; v = (p / HT) % VT;
        return (h < HV) && (v < VV);
    endfunction

    function automatic int addr_of(int p);
        int h, v;
        h = p % HT; v = (p / HT) % VT;
        if (v >= VV) return 0;
        if (h < HV)  return v * HV + h;
        return ((v + 1) * HV) % NP;
    endfunction

    function automatic logic hs_at(int p);
        int h;
        h = p % HT;
        return (h >= HV + HFP) && (h < HV + HFP + HSY);
    endfunction

    function automatic logic vs_at(int p);
        int v;
        v = (p / HT) % VT;
        return (v >= VV + VFP) && (v < VV + VFP + VSY);
    endfunction

    // Error diffusion restarted at every line start: replay the line up to pixel p.
    function automatic logic [23:0] dith_px(int p);
        int h, v, err, s, q;
        logic [23:0] r;
        logic [23:0] w;
        h = p % HT; v = (p / HT) % VT;
        r = 24'h0;
        for (int c = 0; c < 3; c++) begin
            err = 0; q = 0;
            for (int i = 0; i <= h; i++) begin
                w = mem[v * HV + i];
                s = clamp8(int'(w[8*c +: 8]) + err);
                q = quant(s);
                err = s - q;
            end
            r[8*c +: 8] = 8'(q);
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int k      = -1;   // pixel index at stage 0 since reset release; -1 while in reset
    int phase  = 0;
    logic mode_arr [256];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s k=%0d phase=%0d got %h want %h", nm, k, phase, a, e);
        end
    endtask

    always @(posedge clk) begin
        logic        v1, v2, mode;
        logic [23:0] exp_in, exp_rgb, px;
        #1;
        if (!rst) k = -1;
        else      k = k + 1;

        if (k >= 1 && ((k - 1) % FR) == 0) mode_arr[((k - 1) / FR) % 256] = dither_on;

        v1 = (k >= 1) && act(k - 1);
        v2 = (k >= 2) && act(k - 2);
        exp_in  = v1 ? mem[addr_of(k - 1)] : 24'h0;
        exp_rgb = 24'h0;
        if (v2) begin
            px   = mem[addr_of(k - 2)];
            mode = mode_arr[((k - 2) / FR) % 256];
            exp_rgb = mode ? dith_px(k - 2) : (px & 24'hF0F0F0);
        end

        chk("fb_rd",        32'(fb_rd),        32'((k >= 0) && act(k)));
        chk("fb_addr",      32'(fb_addr),      32'((k >= 0) ? addr_of(k) : 0));
        chk("dith_visible", 32'(dith_visible), 32'(v1));
        chk("dith_in",      32'(dith_in),      32'(exp_in));
        chk("dith_rst",     32'(dith_rst),     32'(k <= 0));
        chk("vga_rgb",      32'(vga_rgb),      32'(exp_rgb));
        chk("hsync",        32'(hsync),        32'(!((k >= 2) && hs_at(k - 2))));
        chk("vsync",        32'(vsync),        32'(!((k >= 2) && vs_at(k - 2))));
        chk("frame_start",  32'(frame_start),  32'((k >= 2) && ((k - 2) % FR) == 0));

        // Hand-computed anchors for the model.
        if (k == -1 && phase > 0) begin
            chk("lit_rst_rgb",   32'(vga_rgb), 32'h0);
            chk("lit_rst_hsync", 32'(hsync),   32'h1);
        end
        if (k == 2)      chk("lit_fs_first", 32'(frame_start), 32'h1);
        if (k == HT - 1) chk("lit_addr_hblank", 32'(fb_addr), 32'd16);
        if (k == HT)     chk("lit_addr_line1",  32'(fb_addr), 32'd16);
        if (k == 4 * HT) chk("lit_addr_vblank", 32'(fb_addr), 32'd0);
        if (k == FR)     chk("lit_addr_wrap",   32'(fb_addr), 32'd0);
        if (phase == 1) begin
            // 0x0C with the rounding engine: 10,10,00,10 repeating from each line start.
            if (k - 2 == FR)              chk("lit_dith_l0p0", 32'(vga_rgb), 32'h101010);
            if (k - 2 == FR + 2 * HT)     chk("lit_dith_l2p0", 32'(vga_rgb), 32'h101010);
            if (k - 2 == FR + 2 * HT + 1) chk("lit_dith_l2p1", 32'(vga_rgb), 32'h101010);
            if (k - 2 == FR + 2 * HT + 2) chk("lit_dith_l2p2", 32'(vga_rgb), 32'h000000);
            if (k - 2 == FR + 2 * HT + 3) chk("lit_dith_l2p3", 32'(vga_rgb), 32'h101010);
        end
        if (phase == 2 && k - 2 == FR + 1) chk("lit_trunc_off", 32'(vga_rgb), 32'h0);
        if (phase == 2 && k == FR + 2)     chk("lit_fs_second", 32'(frame_start), 32'h1);
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n, input bit toggle);
        repeat (n) begin
            @(negedge clk);
            if (toggle && ($urandom % 25) == 0) dither_on = ~dither_on;
        end
    endtask

    initial begin
        rst = 1'b0;
        dither_on = 1'b1;
        for (int i = 0; i < NP; i++) mem[i] = 24'h0C0C0C;
        for (int i = 0; i < 256; i++) mode_arr[i] = 1'b0;
        phase = 1;
        cycles(4, 0);
        rst = 1'b1;
        cycles(2 * FR + 10, 0);

        // Mid-frame reset, then constant colour with dithering off.
        rst = 1'b0;
        dither_on = 1'b0;
        phase = 2;
        cycles(3, 0);
        rst = 1'b1;
        cycles(FR + 37, 0);

        // Mid-line reset, then random framebuffer contents and random mode toggles.
        rst = 1'b0;
        phase = 3;
        for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
        cycles(3, 0);
        rst = 1'b1;
        cycles(6 * FR + 50, 1);

        rst = 1'b0;
        phase = 4;
        for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
        cycles(3, 0);
        rst = 1'b1;
        cycles(2 * FR, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
